softmax_input_loader: RTL and testbench

SOFTMAX_INPUT_LOADER -- requirements
Module: softmax_input_loader

---
 rtl/softmax_input_loader_pkg.sv | 29 ++
 rtl/softmax_loader_mem.sv | 36 +++
 rtl/softmax_input_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_softmax_input_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_input_loader_pkg.sv
// Shared definitions for the softmax input loader: FSM encoding, default
// geometry and the pad-lane value used when SOFTMAX_LOADER_PAD_EN is defined.
package softmax_input_loader_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_NUM       = 4;
  localparam int DEF_ADDRSIZE  = 8;

  // Widest element the pad helper can describe.
  localparam int PAD_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_INIT  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // Most-negative two's-complement value of a dw-bit element (MSB set, rest 0),
  // returned right-aligned in a PAD_MAX_W-bit vector.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input int dw);
    logic [PAD_MAX_W-1:0] one_v;
    one_v = {{(PAD_MAX_W-1){1'b0}}, 1'b1};
    return one_v << (dw - 1);
  endfunction

endpackage

// File: rtl/softmax_loader_mem.sv
// Word memory for the softmax input loader: one synchronous write port and
// three asynchronous read ports. Contents are never reset.
module softmax_loader_mem
  import softmax_input_loader_pkg::*;
#(
  parameter int WIDTH    = DEF_DATAWIDTH * DEF_NUM,
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDRSIZE-1:0] rd0_addr,
  input  logic [ADDRSIZE-1:0] rd1_addr,
  input  logic [ADDRSIZE-1:0] rd2_addr,
  output logic [WIDTH-1:0]    rd0_data,
  output logic [WIDTH-1:0]    rd1_data,
  output logic [WIDTH-1:0]    rd2_data
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: a word lands at the clock edge, so same-cycle reads see the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rd0_data = mem_r[rd0_addr];
  assign rd1_data = mem_r[rd1_addr];
  assign rd2_data = mem_r[rd2_addr];

endmodule

// File: rtl/softmax_input_loader.sv
// Softmax input loader: packs a stream of elements NUM-per-word into a local
// memory, then hands the vector bounds to the softmax engine with one-cycle
// init/start pulses and waits for its done handshake.
// Build option: SOFTMAX_LOADER_PAD_EN pads unfilled lanes of a partial last
// word with the most-negative value and treats that word as legal; without it
// unfilled lanes are zero and a partial last word raises err.
module softmax_input_loader
  import softmax_input_loader_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM       = DEF_NUM,
  parameter int ADDRSIZE  = DEF_ADDRSIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATAWIDTH-1:0]      in_data,
  input  logic                      in_last,
  input  logic [ADDRSIZE-1:0]       rd0_addr,
  input  logic [ADDRSIZE-1:0]       rd1_addr,
  input  logic [ADDRSIZE-1:0]       rd2_addr,
  output logic [DATAWIDTH*NUM-1:0]  rd0_data,
  output logic [DATAWIDTH*NUM-1:0]  rd1_data,
  output logic [DATAWIDTH*NUM-1:0]  rd2_data,
  output logic                      sm_init,
  output logic                      sm_start,
  output logic [ADDRSIZE-1:0]       sm_start_addr,
  output logic [ADDRSIZE-1:0]       sm_end_addr,
  input  logic                      sm_done,
  output logic                      busy,
  output logic                      err
);

  localparam int                  WORDW     = DATAWIDTH * NUM;
  localparam int                  LANEW     = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [LANEW-1:0]    LAST_LANE = LANEW'(NUM - 1);
  localparam logic [LANEW-1:0]    LANE_ONE  = LANEW'(32'd1);
  localparam logic [ADDRSIZE-1:0] WORD_ONE  = ADDRSIZE'(32'd1);
  // The top address is kept free so the exclusive end bound always fits.
  localparam logic [ADDRSIZE-1:0] MAX_WORD  = {ADDRSIZE{1'b1}};

`ifdef SOFTMAX_LOADER_PAD_EN
  localparam logic [PAD_MAX_W-1:0] PAD_FULL    = pad_value(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] FILL_LANE   = PAD_FULL[DATAWIDTH-1:0];
  localparam logic                 PARTIAL_ERR = 1'b0;
`else
  localparam logic [DATAWIDTH-1:0] FILL_LANE   = {DATAWIDTH{1'b0}};
  localparam logic                 PARTIAL_ERR = 1'b1;
`endif

  state_t              state_r;
  logic [LANEW-1:0]    lane_r;
  logic [ADDRSIZE-1:0] word_r;
  logic [WORDW-1:0]    pack_r;
  logic                drop_r;
  logic                in_ready_r;
  logic                sm_init_r;
  logic                sm_start_r;
  logic                busy_r;
  logic                err_r;
  logic [ADDRSIZE-1:0] end_addr_r;

  logic                accept_s;
  logic                dropping_s;
  logic [LANEW-1:0]    lane_s;
  logic [ADDRSIZE-1:0] word_s;
  logic                word_done_s;
  logic                ovf_s;
  logic                partial_s;
  logic                wr_en_s;
  logic [WORDW-1:0]    wr_word_s;

  // Reset masks the ready flag so no beat is taken while reset is held.
  assign in_ready      = in_ready_r & ~reset;
  assign sm_init       = sm_init_r;
  assign sm_start      = sm_start_r;
  assign sm_start_addr = {ADDRSIZE{1'b0}};
  assign sm_end_addr   = end_addr_r;
  assign busy          = busy_r;
  assign err           = err_r;

  // Beat acceptance, effective counters (cleared on a vector's first beat) and the assembled write word.
  always_comb begin
    accept_s   = in_valid & in_ready;
    dropping_s = drop_r & (state_r == ST_FILL);
    if (state_r == ST_IDLE) begin
      lane_s = {LANEW{1'b0}};
      word_s = {ADDRSIZE{1'b0}};
    end else begin
      lane_s = lane_r;
      word_s = word_r;
    end
    word_done_s = accept_s & ~dropping_s & ((lane_s == LAST_LANE) | in_last);
    ovf_s       = word_done_s & (word_s == MAX_WORD);
    wr_en_s     = word_done_s & ~ovf_s;
    partial_s   = (lane_s != LAST_LANE);
    wr_word_s   = pack_r;
    for (int k = 0; k < NUM; k++) begin
      if (LANEW'(k) < lane_s) begin
        wr_word_s[k*DATAWIDTH +: DATAWIDTH] = pack_r[k*DATAWIDTH +: DATAWIDTH];
      end else if (LANEW'(k) == lane_s) begin
        wr_word_s[k*DATAWIDTH +: DATAWIDTH] = in_data;
      end else begin
        wr_word_s[k*DATAWIDTH +: DATAWIDTH] = FILL_LANE;
      end
    end
  end

  // Loader FSM: packing, overflow drop, softmax handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      lane_r     <= {LANEW{1'b0}};
      word_r     <= {ADDRSIZE{1'b0}};
      pack_r     <= {WORDW{1'b0}};
      drop_r     <= 1'b0;
      in_ready_r <= 1'b1;
      sm_init_r  <= 1'b0;
      sm_start_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      end_addr_r <= {ADDRSIZE{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (accept_s) begin
            if (dropping_s) begin
              if (in_last) begin
                state_r <= ST_IDLE;
                drop_r  <= 1'b0;
                busy_r  <= 1'b0;
              end
            end else if (word_done_s) begin
              lane_r <= {LANEW{1'b0}};
              if (ovf_s) begin
                err_r <= 1'b1;
                if (in_last) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end else begin
                  state_r <= ST_FILL;
                  drop_r  <= 1'b1;
                  busy_r  <= 1'b1;
                end
              end else begin
                word_r <= word_s + WORD_ONE;
                if (in_last) begin
                  state_r    <= ST_INIT;
                  sm_init_r  <= 1'b1;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  end_addr_r <= word_s + WORD_ONE;
                  if (partial_s && PARTIAL_ERR) begin
                    err_r <= 1'b1;
                  end
                end else begin
                  state_r <= ST_FILL;
                  busy_r  <= 1'b1;
                end
              end
            end else begin
              pack_r[int'(lane_s)*DATAWIDTH +: DATAWIDTH] <= in_data;
              lane_r  <= lane_s + LANE_ONE;
              word_r  <= word_s;
              state_r <= ST_FILL;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          sm_init_r  <= 1'b0;
          sm_start_r <= 1'b1;
          state_r    <= ST_START;
        end
        ST_START: begin
          sm_start_r <= 1'b0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sm_done) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!sm_done) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          drop_r     <= 1'b0;
          sm_init_r  <= 1'b0;
          sm_start_r <= 1'b0;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  softmax_loader_mem #(
    .WIDTH    (WORDW),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk      (clk),
    .we       (wr_en_s),
    .waddr    (word_s),
    .wdata    (wr_word_s),
    .rd0_addr (rd0_addr),
    .rd1_addr (rd1_addr),
    .rd2_addr (rd2_addr),
    .rd0_data (rd0_data),
    .rd1_data (rd1_data),
    .rd2_data (rd2_data)
  );

endmodule

// File: tb/tb_softmax_input_loader.sv
// Self-checking bench for softmax_input_loader (default geometry 16x4, 256 words).
// Expected memory words and error flag come from a vector-level model that
// slices the beat list into NUM-element words.
module tb_softmax_input_loader;

  localparam int DW    = 16;
  localparam int NW    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

`ifdef SOFTMAX_LOADER_PAD_EN
  localparam logic [15:0] PADV     = 16'h8000;
  localparam bit          PART_ERR = 1'b0;
`else
  localparam logic [15:0] PADV     = 16'h0000;
  localparam bit          PART_ERR = 1'b1;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [AW-1:0] rd0_addr, rd1_addr, rd2_addr;
  logic [63:0]   rd0_data, rd1_data, rd2_data;
  logic          sm_init, sm_start;
  logic [AW-1:0] sm_start_addr, sm_end_addr;
  logic          sm_done;
  logic          busy, err;

  softmax_input_loader #(.DATAWIDTH(DW), .NUM(NW), .ADDRSIZE(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .sm_init(sm_init), .sm_start(sm_start),
    .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
    .sm_done(sm_done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] mem_m   [DEPTH];
  bit          valid_m [DEPTH];
  bit          err_m;
  logic [15:0] beats_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vector-level model: element i lands in word i/NW, lane i%NW; missing lanes pad.
  task automatic model_vector();
    int n;
    int nwords;
    logic [63:0] w;
    n = beats_q.size();
    nwords = (n + NW - 1) / NW;
    for (int wi = 0; wi < nwords; wi++) begin
      w = 64'd0;
      for (int k = 0; k < NW; k++) begin
        if (wi * NW + k < n) w[k*DW +: DW] = beats_q[wi*NW + k];
        else                 w[k*DW +: DW] = PADV;
      end
      mem_m[wi]   = w;
      valid_m[wi] = 1'b1;
    end
    if ((n % NW) != 0 && PART_ERR) err_m = 1'b1;
  endtask

  // Compare every model-known word, three distinct addresses per cycle.
  task automatic check_mem();
    int addrs[$];
    int a0, a1, a2;
    for (int a = 0; a < DEPTH; a++) if (valid_m[a]) addrs.push_back(a);
    for (int j = 0; j < addrs.size(); j += 3) begin
      a0 = addrs[j];
      a1 = addrs[(j + 1) % addrs.size()];
      a2 = addrs[(j + 2) % addrs.size()];
      @(negedge clk);
      rd0_addr = 8'(a0); rd1_addr = 8'(a1); rd2_addr = 8'(a2);
      #1;
      check("rd0_word", rd0_data, mem_m[a0]);
      check("rd1_word", rd1_data, mem_m[a1]);
      check("rd2_word", rd2_data, mem_m[a2]);
    end
  endtask

  // Present beats_q with random idle gaps; sm_done wiggles in gaps and must be ignored.
  task automatic drive_beats(input int gap_max);
    int gaps;
    for (int i = 0; i < beats_q.size(); i++) begin
      gaps = $urandom_range(0, gap_max);
      repeat (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        sm_done  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = beats_q[i];
      in_last  = (i == beats_q.size() - 1);
      sm_done  = 1'b0;
      check("in_ready_fill", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // From the INIT cycle: check pulses, bounds, blocked input, done handshake and memory.
  task automatic complete_vector(input int hold);
    int nwords;
    int wcyc;
    nwords = (beats_q.size() + NW - 1) / NW;
    check("init_pulse",   64'(sm_init), 64'd1);
    check("init_nostart", 64'(sm_start), 64'd0);
    check("init_busy",    64'(busy), 64'd1);
    check("init_ready",   64'(in_ready), 64'd0);
    check("end_addr",     64'(sm_end_addr), 64'(nwords));
    check("start_addr",   64'(sm_start_addr), 64'd0);
    sm_done  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hdead;
    @(negedge clk);
    check("start_pulse",  64'(sm_start), 64'd1);
    check("start_noinit", 64'(sm_init), 64'd0);
    check("start_ready",  64'(in_ready), 64'd0);
    sm_done = 1'b0;
    wcyc = $urandom_range(2, 5);
    for (int c = 0; c < wcyc; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      check("wait_ready", 64'(in_ready), 64'd0);
      check("wait_start", 64'(sm_start), 64'd0);
      check("wait_busy",  64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    sm_done  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("drain_busy",  64'(busy), 64'd1);
      check("drain_ready", 64'(in_ready), 64'd0);
      check("drain_end",   64'(sm_end_addr), 64'(nwords));
    end
    sm_done = 1'b0;
    @(negedge clk);
    check("idle_busy",  64'(busy), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);
    model_vector();
    check("err_flag", 64'(err), 64'(err_m));
    check_mem();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w255_before;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; sm_done = 1'b0;
    rd0_addr = 8'd0; rd1_addr = 8'd0; rd2_addr = 8'd0;
    err_m = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin valid_m[a] = 1'b0; mem_m[a] = 64'd0; end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",   64'(in_ready), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_init",    64'(sm_init), 64'd0);
    check("rst_start",   64'(sm_start), 64'd0);
    check("rst_err",     64'(err), 64'd0);
    check("rst_end",     64'(sm_end_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Eight beats 1..8: two full words
    beats_q.delete();
    for (int i = 1; i <= 8; i++) beats_q.push_back(16'(i));
    drive_beats(0);
    complete_vector(2);
    @(negedge clk);
    rd0_addr = 8'd0; rd1_addr = 8'd1;
    #1;
    check("dir_word0", rd0_data, 64'h0004_0003_0002_0001);
    check("dir_word1", rd1_data, 64'h0008_0007_0006_0005);
    check("dir_err",   64'(err), 64'd0);

    // Five beats: partial second word
    beats_q.delete();
    for (int i = 1; i <= 5; i++) beats_q.push_back(16'(i));
    drive_beats(0);
    complete_vector(1);
    @(negedge clk);
    rd0_addr = 8'd1;
    #1;
    check("partial_word1", rd0_data, {PADV, PADV, PADV, 16'd5});
    check("partial_err",   64'(err), 64'(PART_ERR));

    // Reset after three beats abandons the vector
    beats_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("midrst_busy",  64'(busy), 64'd0);
    check("midrst_init",  64'(sm_init), 64'd0);
    check("midrst_err",   64'(err), 64'd0);
    reset = 1'b0;
    err_m = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_noinit",  64'(sm_init), 64'd0);
      check("midrst_nostart", 64'(sm_start), 64'd0);
      check("midrst_idle",    64'(busy), 64'd0);
    end
    for (int i = 0; i < 4; i++) beats_q.push_back(16'($urandom));
    drive_beats(1);
    complete_vector(2);

    // Single beat, sm_done held three cycles
    beats_q.delete();
    beats_q.push_back(16'($urandom));
    drive_beats(0);
    complete_vector(3);

    // Random vectors
    for (int v = 0; v < 6; v++) begin
      beats_q.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) beats_q.push_back(16'($urandom));
      drive_beats(2);
      complete_vector($urandom_range(1, 4));
    end

    // Overflow: 255 words fit, the 256th word write is refused
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_m = 1'b0;
    for (int a = 0; a < DEPTH; a++) valid_m[a] = 1'b0;
    rd0_addr = 8'd255;
    #1;
    w255_before = rd0_data;
    beats_q.delete();
    for (int i = 0; i < 1030; i++) begin
      @(negedge clk);
      if (i == 1020) check("ovf_err_before", 64'(err), 64'd0);
      if (i == 1024) check("ovf_err_set",    64'(err), 64'd1);
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = (i == 1029);
      if (i < 1020) beats_q.push_back(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ovf_idle_busy",  64'(busy), 64'd0);
    check("ovf_idle_ready", 64'(in_ready), 64'd1);
    check("ovf_err",        64'(err), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ovf_noinit",  64'(sm_init), 64'd0);
      check("ovf_nostart", 64'(sm_start), 64'd0);
      check("ovf_nobusy",  64'(busy), 64'd0);
    end
    rd0_addr = 8'd255;
    #1;
    check("ovf_word255_kept", rd0_data, w255_before);
    model_vector();
    check_mem();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
